// File: rtl/instr_decode.sv
// Instruction decode/dispatch stage: buffers fetched words in a small FIFO and
// issues load and conv commands over valid/ready, holding conv behind the load unit.
module instr_decode #(
  parameter int         DEPTH   = 8,
  parameter logic [7:0] OP_LOAD = 8'h04,
  parameter logic [7:0] OP_CONV = 8'h81
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [63:0]                i_instr,
  input  logic [4:0]                 i_instr_addr,
  input  logic                       i_instr_enable,
  output logic                       ld_valid,
  input  logic                       ld_ready,
  input  logic                       ld_busy,
  output logic [7:0]                 ld_ftype,
  output logic [15:0]                ld_saddr,
  output logic [15:0]                ld_daddr,
  output logic [7:0]                 ld_memsel,
  output logic                       conv_valid,
  input  logic                       conv_ready,
  output logic [15:0]                conv_saddr,
  output logic [15:0]                conv_daddr,
  output logic [7:0]                 conv_memsel,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       ovf_err,
  output logic                       op_err,
  output logic [4:0]                 op_err_addr,
  output logic [15:0]                issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_LOAD,
    S_BARRIER,
    S_CONV
  } state_t;

  // Byte 0 of the instruction carries nothing, so it is never stored.
  typedef struct packed {
    logic [4:0]  addr;
    logic [7:0]  opcode;
    logic [7:0]  ftype;
    logic [15:0] saddr;
    logic [15:0] daddr;
    logic [7:0]  memsel;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          cur;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  state_t          state;
  state_t          state_next;
  logic            push;
  logic            pop;
  logic            ld_hs;
  logic            conv_hs;
  logic            unused_low_byte;

  assign unused_low_byte = ^i_instr[7:0];

  // Full check uses the pre-edge count, so a same-cycle pop cannot make room.
  assign push    = i_instr_enable && (count < CW'(DEPTH));
  assign pop     = (state == S_IDLE) && (count != '0);
  assign ld_hs   = ld_valid && ld_ready;
  assign conv_hs = conv_valid && conv_ready;

  // NOTE: storage array is deliberately not reset; occupancy is tracked by
  // pointers/count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr:   i_instr_addr,
                       opcode: i_instr[63:56],
                       ftype:  i_instr[55:48],
                       saddr:  i_instr[47:32],
                       daddr:  i_instr[31:16],
                       memsel: i_instr[15:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= '0;
      ovf_err     <= 1'b0;
      op_err      <= 1'b0;
      op_err_addr <= '0;
      issued_cnt  <= '0;
    end else begin
      if (pop) cur <= mem[rd_ptr];
      if (i_instr_enable && !push) ovf_err <= 1'b1;
      if (state == S_DECODE && cur.opcode != OP_LOAD && cur.opcode != OP_CONV) begin
        op_err <= 1'b1;
        if (!op_err) op_err_addr <= cur.addr;
      end
      if (ld_hs || conv_hs) issued_cnt <= issued_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (pop) state_next = S_DECODE;
      S_DECODE: begin
        if (cur.opcode == OP_LOAD)      state_next = S_LOAD;
        else if (cur.opcode == OP_CONV) state_next = ld_busy ? S_BARRIER : S_CONV;
        else                            state_next = S_IDLE;
      end
      S_LOAD:    if (ld_hs)    state_next = S_IDLE;
      S_BARRIER: if (!ld_busy) state_next = S_CONV;
      S_CONV:    if (conv_hs)  state_next = S_IDLE;
      default:                 state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ld_valid   = 1'b0;
    conv_valid = 1'b0;
    case (state)
      S_LOAD:  ld_valid   = 1'b1;
      S_CONV:  conv_valid = 1'b1;
      default: ;
    endcase
  end

  // Fields come straight from the held word, so they cannot move while valid.
  assign ld_ftype    = cur.ftype;
  assign ld_saddr    = cur.saddr;
  assign ld_daddr    = cur.daddr;
  assign ld_memsel   = cur.memsel;
  assign conv_saddr  = cur.saddr;
  assign conv_daddr  = cur.daddr;
  assign conv_memsel = cur.memsel;
  assign fifo_count  = count;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: a transaction-level model is compared every
// cycle, and literal expectations pin the key scenarios.
module tb_instr_decode;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] i_instr = '0;
  logic [4:0]  i_instr_addr = '0;
  logic        i_instr_enable = 1'b0;
  logic        ld_valid, ld_ready = 1'b0, ld_busy = 1'b0;
  logic [7:0]  ld_ftype, ld_memsel, conv_memsel;
  logic [15:0] ld_saddr, ld_daddr, conv_saddr, conv_daddr, issued_cnt;
  logic        conv_valid, conv_ready = 1'b0;
  logic [3:0]  fifo_count;
  logic        ovf_err, op_err;
  logic [4:0]  op_err_addr;

  always #5 clk = ~clk;

  instr_decode #(.DEPTH(DEPTH), .OP_LOAD(8'h04), .OP_CONV(8'h81)) dut (
    .clk(clk), .rst(rst),
    .i_instr(i_instr), .i_instr_addr(i_instr_addr), .i_instr_enable(i_instr_enable),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_busy(ld_busy),
    .ld_ftype(ld_ftype), .ld_saddr(ld_saddr), .ld_daddr(ld_daddr), .ld_memsel(ld_memsel),
    .conv_valid(conv_valid), .conv_ready(conv_ready),
    .conv_saddr(conv_saddr), .conv_daddr(conv_daddr), .conv_memsel(conv_memsel),
    .fifo_count(fifo_count), .ovf_err(ovf_err), .op_err(op_err),
    .op_err_addr(op_err_addr), .issued_cnt(issued_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: buffered words, the word being worked on, and what it is waiting for.
  localparam int P_EMPTY = 0, P_HELD = 1, P_LOAD_OUT = 2, P_WAIT_IDLE = 3, P_CONV_OUT = 4;
  logic [68:0] mq[$];
  logic [68:0] m_cur;
  int          m_phase;
  int          pre;
  logic [15:0] m_issued;
  logic        m_ovf, m_operr;
  logic [4:0]  m_operr_addr;
  logic [7:0]  m_op;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_cur = '0; m_phase = P_EMPTY; m_issued = '0;
      m_ovf = 1'b0; m_operr = 1'b0; m_operr_addr = '0;
    end else begin
      pre = mq.size();
      case (m_phase)
        P_EMPTY: if (pre > 0) begin m_cur = mq.pop_front(); m_phase = P_HELD; end
        P_HELD: begin
          m_op = m_cur[63:56];
          if (m_op == 8'h04)      m_phase = P_LOAD_OUT;
          else if (m_op == 8'h81) m_phase = ld_busy ? P_WAIT_IDLE : P_CONV_OUT;
          else begin
            if (!m_operr) m_operr_addr = m_cur[68:64];
            m_operr = 1'b1;
            m_phase = P_EMPTY;
          end
        end
        P_LOAD_OUT:  if (ld_ready)   begin m_issued = m_issued + 16'd1; m_phase = P_EMPTY; end
        P_WAIT_IDLE: if (!ld_busy)   m_phase = P_CONV_OUT;
        P_CONV_OUT:  if (conv_ready) begin m_issued = m_issued + 16'd1; m_phase = P_EMPTY; end
        default: m_phase = P_EMPTY;
      endcase
      if (i_instr_enable) begin
        if (pre < DEPTH) mq.push_back({i_instr_addr, i_instr});
        else             m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("ld_valid", ld_valid, m_phase == P_LOAD_OUT);
      check("conv_valid", conv_valid, m_phase == P_CONV_OUT);
      check("valid_excl", ld_valid & conv_valid, 0);
      check("fifo_count", fifo_count, mq.size());
      check("issued_cnt", issued_cnt, m_issued);
      check("ovf_err", ovf_err, m_ovf);
      check("op_err", op_err, m_operr);
      check("op_err_addr", op_err_addr, m_operr_addr);
      if (m_phase == P_LOAD_OUT) begin
        check("ld_ftype", ld_ftype, m_cur[55:48]);
        check("ld_saddr", ld_saddr, m_cur[47:32]);
        check("ld_daddr", ld_daddr, m_cur[31:16]);
        check("ld_memsel", ld_memsel, m_cur[15:8]);
      end
      if (m_phase == P_CONV_OUT) begin
        check("conv_saddr", conv_saddr, m_cur[47:32]);
        check("conv_daddr", conv_daddr, m_cur[31:16]);
        check("conv_memsel", conv_memsel, m_cur[15:8]);
      end
    end
  end

  // Source addresses of loads the DUT actually handed over.
  logic [15:0] dut_log[$];
  always @(posedge clk) if (!rst && ld_valid && ld_ready) dut_log.push_back(ld_saddr);

  function automatic logic [63:0] mk(input logic [7:0] op, input logic [15:0] sa,
                                     input logic [15:0] da, input logic [7:0] ms);
    return {op, 8'h00, sa, da, ms, 8'h00};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] a, input logic [63:0] w);
    i_instr_addr   = a;
    i_instr        = w;
    i_instr_enable = 1'b1;
    @(negedge clk);
    i_instr_enable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    rst = 1'b0;
    started = 1'b1;
    check("rst_ld_valid", ld_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_issued", issued_cnt, 0);

    // Single load, latency and field map.
    ld_ready = 1'b1;
    drive(5'd1, 64'h0400000100010100);
    check("t1_count", fifo_count, 1);
    cyc(1);
    check("t1_not_yet", ld_valid, 0);
    cyc(1);
    check("t1_valid", ld_valid, 1);
    check("t1_ftype", ld_ftype, 8'h00);
    check("t1_saddr", ld_saddr, 16'h0001);
    check("t1_daddr", ld_daddr, 16'h0001);
    check("t1_memsel", ld_memsel, 8'h01);
    cyc(1);
    check("t1_one_cycle", ld_valid, 0);
    check("t1_issued", issued_cnt, 1);

    // Backpressure on five loads, then in-order release.
    ld_ready = 1'b0;
    dut_log.delete();
    for (int i = 0; i < 5; i++) begin
      i_instr_addr = 5'(i); i_instr = mk(8'h04, 16'h0010 + 16'(i), 16'h0200, 8'h02);
      i_instr_enable = 1'b1;
      @(negedge clk);
    end
    i_instr_enable = 1'b0;
    cyc(20);
    check("t2_held", ld_valid, 1);
    check("t2_saddr", ld_saddr, 16'h0010);
    check("t2_count", fifo_count, 4);
    ld_ready = 1'b1;
    cyc(25);
    check("t2_log_size", dut_log.size(), 5);
    for (int i = 0; i < 5 && i < dut_log.size(); i++)
      check("t2_order", dut_log[i], 16'h0010 + 16'(i));
    check("t2_issued", issued_cnt, 6);

    // Conv behind a busy load unit.
    ld_busy = 1'b1; conv_ready = 1'b1;
    drive(5'd5, 64'h8100000400040100);
    cyc(6);
    check("t3_barrier", conv_valid, 0);
    ld_busy = 1'b0;
    cyc(1);
    check("t3_conv_valid", conv_valid, 1);
    check("t3_saddr", conv_saddr, 16'h0004);
    check("t3_daddr", conv_daddr, 16'h0004);
    check("t3_memsel", conv_memsel, 8'h01);
    cyc(1);
    check("t3_done", conv_valid, 0);
    check("t3_issued", issued_cnt, 7);

    // Unknown opcode followed by a good load.
    dut_log.delete();
    drive(5'd6, mk(8'h07, 16'h0066, 16'h0066, 8'h06));
    drive(5'd7, mk(8'h04, 16'h0077, 16'h0077, 8'h07));
    cyc(10);
    check("t4_op_err", op_err, 1);
    check("t4_op_err_addr", op_err_addr, 5'd6);
    check("t4_log_size", dut_log.size(), 1);
    if (dut_log.size() > 0) check("t4_load", dut_log[0], 16'h0077);
    check("t4_issued", issued_cnt, 8);

    // Overflow: DEPTH+2 words with ready low.
    ld_ready = 1'b0;
    dut_log.delete();
    for (int i = 0; i < DEPTH + 2; i++) begin
      i_instr_addr = 5'(i); i_instr = mk(8'h04, 16'h0100 + 16'(i), 16'h0300, 8'h03);
      i_instr_enable = 1'b1;
      @(negedge clk);
    end
    i_instr_enable = 1'b0;
    cyc(2);
    check("t5_count", fifo_count, DEPTH);
    check("t5_ovf", ovf_err, 1);
    ld_ready = 1'b1;
    cyc(40);
    check("t5_log_size", dut_log.size(), DEPTH + 1);
    for (int i = 0; i < DEPTH + 1 && i < dut_log.size(); i++)
      check("t5_order", dut_log[i], 16'h0100 + 16'(i));
    check("t5_issued", issued_cnt, 17);

    // Reset mid-handshake.
    ld_ready = 1'b0;
    drive(5'd9, mk(8'h04, 16'h0999, 16'h0999, 8'h09));
    drive(5'd10, mk(8'h04, 16'h0aaa, 16'h0aaa, 8'h0a));
    cyc(4);
    check("t6_pre_valid", ld_valid, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t6_ld_valid", ld_valid, 0);
    check("t6_count", fifo_count, 0);
    check("t6_ovf", ovf_err, 0);
    check("t6_op_err", op_err, 0);
    check("t6_issued", issued_cnt, 0);
    ld_ready = 1'b1;
    cyc(5);
    check("t6_no_replay", issued_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Sits directly downstream of the instruction fetch stage. Consumes its 64-bit instruction stream (instr, addr, enable) and buffers it in a small FIFO.
- Decodes the opcode and dispatches load-feature commands to the load unit and conv commands to the conv engine, each over a valid/ready handshake.
- Enforces a load→conv barrier: a conv command is not issued until the load unit reports idle.
- Flags unknown opcodes and FIFO overflow.

Parameters:
- DEPTH, 8, instruction FIFO entries (power of 2, ≥2).
- OP_LOAD, 8'h04, opcode of load-feature instruction.
- OP_CONV, 8'h81, opcode of conv instruction.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- i_instr  in  64  instruction word from fetch.
- i_instr_addr  in  5  instruction index from fetch.
- i_instr_enable  in  1  i_instr/i_instr_addr valid this cycle; no backpressure.
- ld_valid  out  1  load command valid.
- ld_ready  in  1  load unit accepts command.
- ld_busy  in  1  load unit has outstanding transfers.
- ld_ftype  out  8  feature type field.
- ld_saddr  out  16  source address.
- ld_daddr  out  16  destination address.
- ld_memsel  out  8  target memory select.
- conv_valid  out  1  conv command valid.
- conv_ready  in  1  conv engine accepts command.
- conv_saddr  out  16  conv source address.
- conv_daddr  out  16  conv destination address.
- conv_memsel  out  8  conv memory select.
- fifo_count  out  log2(DEPTH)+1  current occupancy.
- ovf_err  out  1  sticky: write dropped because FIFO full.
- op_err  out  1  sticky: unknown opcode seen.
- op_err_addr  out  5  instr addr of first unknown opcode.
- issued_cnt  out  16  count of commands dispatched (wraps 16'hFFFF→0).

Behaviour:
- Field map: opcode[63:56], f_type[55:48], saddr={[47:40],[39:32]}, daddr={[31:24],[23:16]}, memsel[15:8]; [7:0] ignored.
- FIFO stores {addr, instr}. Push when i_instr_enable and count<DEPTH, using the pre-edge count. Enable while full: word dropped, ovf_err←1. A pop the same cycle does not free space for that push. Pointers wrap modulo DEPTH.
- FSM states: IDLE, DECODE, LOAD, BARRIER, CONV.
  - IDLE: if count>0, latch head into cur register, pop, →DECODE.
  - DECODE (1 cycle): opcode==OP_LOAD→LOAD. opcode==OP_CONV→CONV if !ld_busy, else BARRIER. Otherwise: set op_err (op_err_addr captured only on first error) and →IDLE; word discarded, no dispatch.
  - LOAD: ld_valid=1 with fields driven from cur. On ld_valid&ld_ready: issued_cnt+1, →IDLE.
  - BARRIER: wait until ld_busy==0, →CONV.
  - CONV: conv_valid=1 with fields. On conv_valid&conv_ready: issued_cnt+1, →IDLE.
- Command fields are stable while valid is high. Valid never drops without a handshake. ld_valid and conv_valid are never high together.
- Latency: word written at edge E0 → popped at E1 → ld_valid high after E2. Best-case throughput is one command per 3 cycles when ready is held high.
- Reset: all outputs 0, FIFO emptied, state IDLE, sticky flags cleared. Reset mid-handshake aborts the command; it is not replayed.
- ld_busy is sampled only in DECODE and BARRIER.

Test Plan:
- Reset, then write 64'h0400000100010100 at addr 1 with ld_ready=1 → ld_valid high 2 cycles after the write edge for 1 cycle; ld_ftype=0, ld_saddr=16'h0001, ld_daddr=16'h0001, ld_memsel=1; issued_cnt=1.
- Write 5 loads back-to-back with ld_ready=0 for 20 cycles → ld_valid held with fields of load 0; fifo_count=4. Release ready → 5 handshakes in order, addrs 0..4.
- Write conv 64'h8100000400040100 with ld_busy=1 → FSM in BARRIER, conv_valid=0. Drop ld_busy → conv_valid next cycle; conv_saddr=16'h0004, conv_daddr=16'h0004, conv_memsel=1.
- Write opcode 8'h07 at addr 6, then a valid load → op_err=1, op_err_addr=6, no dispatch for addr 6; the following load is dispatched normally.
- Hold ready low, write DEPTH+2 words → fifo_count=DEPTH, ovf_err=1, exactly DEPTH+1 commands eventually dispatched (1 in cur register + DEPTH).
- Assert rst while ld_valid is high → next cycle ld_valid=0, fifo_count=0, flags 0, issued_cnt=0.
